// File: rtl/cache_pkg.sv
// Shared constants, FSM state type and address slicing helpers for the
// two-way write-back cache controller.
package cache_pkg;

   localparam int CACHE_ADDR_W   = 16;
   localparam int CACHE_DATA_W   = 8;
   localparam int CACHE_NUM_SETS = 16;
   localparam int CACHE_IDX_W    = $clog2(CACHE_NUM_SETS);
   localparam int CACHE_TAG_W    = CACHE_ADDR_W - CACHE_IDX_W;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      ALLOCATE  = 2'd2
   } cache_state_t;

   function automatic logic [CACHE_IDX_W-1:0] idx_of(input logic [CACHE_ADDR_W-1:0] addr);
      return addr[CACHE_IDX_W-1:0];
   endfunction

   function automatic logic [CACHE_TAG_W-1:0] tag_of(input logic [CACHE_ADDR_W-1:0] addr);
      return addr[CACHE_ADDR_W-1:CACHE_IDX_W];
   endfunction

endpackage

// File: rtl/cache_way_array.sv
// One cache way: valid/dirty/tag/data per set, asynchronous read, single
// full-entry write port. Only valid and dirty bits are cleared by reset.
module cache_way_array #(
   parameter int NUM_SETS = 16,
   parameter int IDX_W    = 4,
   parameter int TAG_W    = 12,
   parameter int DATA_W   = 8
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic [IDX_W-1:0]  rd_idx_i,
   output logic              valid_o,
   output logic              dirty_o,
   output logic [TAG_W-1:0]  tag_o,
   output logic [DATA_W-1:0] data_o,
   input  logic              we_i,
   input  logic [IDX_W-1:0]  wr_idx_i,
   input  logic [TAG_W-1:0]  wr_tag_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              wr_dirty_i
);

   logic [NUM_SETS-1:0] valid_q;
   logic [NUM_SETS-1:0] dirty_q;
   logic [TAG_W-1:0]    tag_q  [NUM_SETS];
   logic [DATA_W-1:0]   data_q [NUM_SETS];

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (we_i) begin
         valid_q[wr_idx_i] <= 1'b1;
         dirty_q[wr_idx_i] <= wr_dirty_i;
      end
   end

   // Tag and data are meaningless while the valid bit is clear, so no reset.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         tag_q[wr_idx_i]  <= wr_tag_i;
         data_q[wr_idx_i] <= wr_data_i;
      end
   end

   assign valid_o = valid_q[rd_idx_i];
   assign dirty_o = dirty_q[rd_idx_i];
   assign tag_o   = tag_q[rd_idx_i];
   assign data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/cache_2way_ctrl.sv
// Two-way set-associative write-back/write-allocate byte cache controller.
// Define CACHE_STATS_EN to add the hit_count/miss_count output ports.
module cache_2way_ctrl
   import cache_pkg::*;
#(
   parameter int ADDR_W   = CACHE_ADDR_W,
   parameter int DATA_W   = CACHE_DATA_W,
   parameter int NUM_SETS = CACHE_NUM_SETS
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] addr_cpu,
   input  logic              rd_cpu,
   input  logic              wr_cpu,
   inout  wire  [DATA_W-1:0] data_cpu,
   output logic              stall_cpu,
   output logic [ADDR_W-1:0] addr_mem,
   output logic              rd_mem,
   output logic              wr_mem,
   inout  wire  [DATA_W-1:0] data_mem,
   input  logic              ready_mem
`ifdef CACHE_STATS_EN
   ,
   output logic [15:0]       hit_count,
   output logic [15:0]       miss_count
`endif
);

   localparam int IDX_W = $clog2(NUM_SETS);
   localparam int TAG_W = ADDR_W - IDX_W;

   cache_state_t        state_q;
   logic [ADDR_W-1:0]   miss_addr_q;
   logic                victim_way_q;
   logic [DATA_W-1:0]   wb_data_q;
   logic [ADDR_W-1:0]   addr_mem_q;
   logic                rd_mem_q;
   logic                wr_mem_q;
   logic [NUM_SETS-1:0] lru_q;

   logic [IDX_W-1:0]    req_idx;
   logic [TAG_W-1:0]    req_tag;
   logic                req;
   logic                hit;
   logic                is_idle;
   logic                rd_hit;
   logic                wr_hit;
   logic                fill;
   logic                victim_way;
   logic                victim_dirty;
   logic [1:0]          way_valid;
   logic [1:0]          way_dirty;
   logic [1:0]          hit_way;
   logic [1:0]          arr_we;
   logic [TAG_W-1:0]    way_tag  [2];
   logic [DATA_W-1:0]   way_data [2];
   logic [IDX_W-1:0]    arr_idx;
   logic [TAG_W-1:0]    arr_tag;
   logic [DATA_W-1:0]   arr_data;

   assign req_idx = addr_cpu[IDX_W-1:0];
   assign req_tag = addr_cpu[ADDR_W-1:IDX_W];
   assign req     = rd_cpu | wr_cpu;

   for (genvar w = 0; w < 2; w++) begin : g_way
      cache_way_array #(
         .NUM_SETS(NUM_SETS),
         .IDX_W   (IDX_W),
         .TAG_W   (TAG_W),
         .DATA_W  (DATA_W)
      ) u_way (
         .clk_i     (clock),
         .rst_n_i   (reset_n),
         .rd_idx_i  (req_idx),
         .valid_o   (way_valid[w]),
         .dirty_o   (way_dirty[w]),
         .tag_o     (way_tag[w]),
         .data_o    (way_data[w]),
         .we_i      (arr_we[w]),
         .wr_idx_i  (arr_idx),
         .wr_tag_i  (arr_tag),
         .wr_data_i (arr_data),
         .wr_dirty_i(!fill)
      );
      assign hit_way[w] = req & way_valid[w] & (way_tag[w] == req_tag);
   end

   assign hit     = |hit_way;
   assign is_idle = (state_q == IDLE);
   assign wr_hit  = is_idle & hit & wr_cpu;
   assign rd_hit  = is_idle & hit & !wr_cpu;
   assign fill    = (state_q == ALLOCATE) & ready_mem;

   assign victim_way   = !way_valid[0] ? 1'b0 : (!way_valid[1] ? 1'b1 : lru_q[req_idx]);
   assign victim_dirty = way_valid[victim_way] & way_dirty[victim_way];

   // Refill and write hit share the write port; they never coincide since
   // a write hit only completes in IDLE.
   assign arr_we[0] = (wr_hit & hit_way[0]) | (fill & !victim_way_q);
   assign arr_we[1] = (wr_hit & hit_way[1]) | (fill &  victim_way_q);
   assign arr_idx   = fill ? miss_addr_q[IDX_W-1:0]      : req_idx;
   assign arr_tag   = fill ? miss_addr_q[ADDR_W-1:IDX_W] : req_tag;
   assign arr_data  = fill ? data_mem                    : data_cpu;

   assign stall_cpu = !is_idle | (req & !hit);
   assign addr_mem  = addr_mem_q;
   assign rd_mem    = rd_mem_q;
   assign wr_mem    = wr_mem_q;
   assign data_cpu  = rd_hit   ? way_data[hit_way[1]] : 'z;
   assign data_mem  = wr_mem_q ? wb_data_q            : 'z;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         miss_addr_q  <= '0;
         victim_way_q <= 1'b0;
         wb_data_q    <= '0;
         addr_mem_q   <= '0;
         rd_mem_q     <= 1'b0;
         wr_mem_q     <= 1'b0;
         lru_q        <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (hit) begin
                  lru_q[req_idx] <= hit_way[0];
               end else if (req) begin
                  miss_addr_q  <= addr_cpu;
                  victim_way_q <= victim_way;
                  if (victim_dirty) begin
                     wb_data_q  <= way_data[victim_way];
                     addr_mem_q <= {way_tag[victim_way], req_idx};
                     wr_mem_q   <= 1'b1;
                     state_q    <= WRITEBACK;
                  end else begin
                     addr_mem_q <= addr_cpu;
                     rd_mem_q   <= 1'b1;
                     state_q    <= ALLOCATE;
                  end
               end
            end
            WRITEBACK: begin
               if (ready_mem) begin
                  wr_mem_q   <= 1'b0;
                  rd_mem_q   <= 1'b1;
                  addr_mem_q <= miss_addr_q;
                  state_q    <= ALLOCATE;
               end
            end
            ALLOCATE: begin
               if (ready_mem) begin
                  rd_mem_q <= 1'b0;
                  state_q  <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef CACHE_STATS_EN
   logic [15:0] hit_count_q;
   logic [15:0] miss_count_q;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         hit_count_q  <= '0;
         miss_count_q <= '0;
      end else begin
         if (is_idle & hit)  hit_count_q  <= hit_count_q + 16'd1;
         if (is_idle & req & !hit) miss_count_q <= miss_count_q + 16'd1;
      end
   end

   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_cache_2way_ctrl.sv
// Scoreboard bench for cache_2way_ctrl: directed scenarios plus random traffic
// checked against a set/way reference model over a flat backing memory.
module tb_cache_2way_ctrl;
   import cache_pkg::*;

   localparam int MEM_LAT = 4;
   localparam int EXP_W   = 17;
   localparam int TIMEOUT = 200;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [15:0] addr_cpu;
   logic        rd_cpu;
   logic        wr_cpu;
   wire  [7:0]  data_cpu;
   logic        stall_cpu;
   logic [15:0] addr_mem;
   logic        rd_mem;
   logic        wr_mem;
   wire  [7:0]  data_mem;
   logic        ready_mem;
   logic [7:0]  cpu_wdata;
`ifdef CACHE_STATS_EN
   logic [15:0] hit_count;
   logic [15:0] miss_count;
`endif

   cache_2way_ctrl dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .addr_cpu (addr_cpu),
      .rd_cpu   (rd_cpu),
      .wr_cpu   (wr_cpu),
      .data_cpu (data_cpu),
      .stall_cpu(stall_cpu),
      .addr_mem (addr_mem),
      .rd_mem   (rd_mem),
      .wr_mem   (wr_mem),
      .data_mem (data_mem),
      .ready_mem(ready_mem)
`ifdef CACHE_STATS_EN
      ,
      .hit_count (hit_count),
      .miss_count(miss_count)
`endif
   );

   always #5 clock = ~clock;

   assign data_cpu = wr_cpu ? cpu_wdata : 'z;

   // Main memory model: mem[a] = a[7:0], ready pulse on the MEM_LAT-th cycle of a request.
   logic [7:0] mem [0:65535];
   int         lat_cnt;

   initial begin
      for (int a = 0; a < 65536; a++) mem[a] = 8'(a);
   end

   assign data_mem = rd_mem ? mem[addr_mem] : 'z;

   always @(posedge clock) begin
      if (!reset_n) begin
         ready_mem <= 1'b0;
         lat_cnt   <= 0;
      end else if (ready_mem) begin
         if (wr_mem) mem[addr_mem] <= data_mem;
         ready_mem <= 1'b0;
      end else if (rd_mem || wr_mem) begin
         if (lat_cnt == MEM_LAT - 2) begin
            ready_mem <= 1'b1;
            lat_cnt   <= 0;
         end else begin
            lat_cnt <= lat_cnt + 1;
         end
      end
   end

   // Scoreboard state
   int n_checks = 0;
   int n_pass   = 0;
   logic [EXP_W-1:0] exp_q  [$];  // {is_read, stall_cycles[7:0], data[7:0]}
   logic [23:0]      wb_q   [$];  // {addr, data}
   logic [15:0]      fill_q [$];
   int               stall_cnt;

   // Reference model
   logic [7:0]  ref_mem  [0:65535];
   bit          ref_valid[16][2];
   bit          ref_dirty[16][2];
   logic [11:0] ref_tag  [16][2];
   logic [7:0]  ref_line [16][2];
   bit          ref_lru  [16];
   int          ref_hits;
   int          ref_misses;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic report();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   endtask

   task automatic model_clear_cache();
      for (int s = 0; s < 16; s++) begin
         ref_lru[s] = 1'b0;
         for (int w = 0; w < 2; w++) begin
            ref_valid[s][w] = 1'b0;
            ref_dirty[s][w] = 1'b0;
         end
      end
      ref_hits   = 0;
      ref_misses = 0;
   endtask

   task automatic model_access(input bit is_wr, input logic [15:0] a, input logic [7:0] wd,
                               output logic [7:0] rdata, output int stl);
      logic [3:0]  idx;
      logic [11:0] tag;
      logic [15:0] va;
      int          way;
      idx = idx_of(a);
      tag = tag_of(a);
      way = -1;
      stl = 0;
      for (int w = 0; w < 2; w++)
         if (ref_valid[idx][w] && ref_tag[idx][w] == tag) way = w;
      if (way < 0) begin
         ref_misses++;
         if (!ref_valid[idx][0])      way = 0;
         else if (!ref_valid[idx][1]) way = 1;
         else                         way = int'(ref_lru[idx]);
         if (ref_valid[idx][way] && ref_dirty[idx][way]) begin
            va = {ref_tag[idx][way], idx};
            wb_q.push_back({va, ref_line[idx][way]});
            ref_mem[va] = ref_line[idx][way];
            stl = 2 * MEM_LAT + 1;
         end else begin
            stl = MEM_LAT + 1;
         end
         fill_q.push_back(a);
         ref_valid[idx][way] = 1'b1;
         ref_dirty[idx][way] = 1'b0;
         ref_tag[idx][way]   = tag;
         ref_line[idx][way]  = ref_mem[a];
      end
      ref_hits++;
      rdata = ref_line[idx][way];
      if (is_wr) begin
         ref_line[idx][way]  = wd;
         ref_dirty[idx][way] = 1'b1;
      end
      ref_lru[idx] = (way == 0);
   endtask

   // Driver: called #1 after a rising edge; returns #1 after the completing edge.
   task automatic issue(input bit do_rd, input bit do_wr, input logic [15:0] a, input logic [7:0] wd);
      logic [7:0] rdata;
      int         stl;
      model_access(do_wr, a, wd, rdata, stl);
      exp_q.push_back({~do_wr, 8'(stl), do_wr ? wd : rdata});
      addr_cpu  = a;
      rd_cpu    = do_rd;
      wr_cpu    = do_wr;
      cpu_wdata = wd;
      for (int c = 0; ; c++) begin
         @(negedge clock);
         if (!stall_cpu) break;
         if (c > TIMEOUT) begin
            $display("FAIL timeout: access at 0x%0h never completed", a);
            n_checks++;
            report();
         end
      end
      @(posedge clock);
      #1;
      rd_cpu = 1'b0;
      wr_cpu = 1'b0;
   endtask

   // Monitor: CPU completions and memory transactions against the queues.
   always @(negedge clock) begin
      logic [EXP_W-1:0] e;
      logic [23:0]      wb;
      logic [15:0]      fa;
      if (!reset_n) begin
         stall_cnt = 0;
      end else begin
         if (rd_cpu || wr_cpu) begin
            if (stall_cpu) begin
               stall_cnt++;
            end else begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  $display("FAIL unexpected_completion: addr 0x%0h, no access pending", addr_cpu);
               end else begin
                  e = exp_q.pop_front();
                  check("stall_cycles", 32'(stall_cnt), 32'(e[15:8]));
                  check(e[16] ? "read_data" : "write_bus", 32'(data_cpu), 32'(e[7:0]));
               end
               stall_cnt = 0;
            end
         end
         if (ready_mem && wr_mem) begin
            if (wb_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_writeback: got addr 0x%0h data 0x%0h, expected none", addr_mem, data_mem);
            end else begin
               wb = wb_q.pop_front();
               check("wb_addr", 32'(addr_mem), 32'(wb[23:8]));
               check("wb_data", 32'(data_mem), 32'(wb[7:0]));
            end
         end
         if (ready_mem && rd_mem) begin
            if (fill_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_fill: got addr 0x%0h, expected none", addr_mem);
            end else begin
               fa = fill_q.pop_front();
               check("fill_addr", 32'(addr_mem), 32'(fa));
            end
         end
      end
   end

   initial begin
      for (int a = 0; a < 65536; a++) ref_mem[a] = 8'(a);
      model_clear_cache();
      reset_n   = 1'b0;
      rd_cpu    = 1'b0;
      wr_cpu    = 1'b0;
      addr_cpu  = '0;
      cpu_wdata = '0;
      repeat (4) @(posedge clock);
      #1;
      reset_n = 1'b1;
      check("reset_rd_mem", 32'(rd_mem), 32'd0);
      check("reset_wr_mem", 32'(wr_mem), 32'd0);
      check("reset_addr_mem", 32'(addr_mem), 32'd0);
      check("reset_stall", 32'(stall_cpu), 32'd0);

      // Cold read miss, write hit, read-back hit
      issue(1, 0, 16'h0093, 8'h00);
      issue(0, 1, 16'h0093, 8'h23);
      issue(1, 0, 16'h0093, 8'h00);

      // Set 3 conflicts: evictions with a dirty victim write-back
      issue(1, 0, 16'h0013, 8'h00);
      issue(1, 0, 16'h0023, 8'h00);
      issue(1, 0, 16'h0013, 8'h00);
      issue(1, 0, 16'h0033, 8'h00);
      issue(1, 0, 16'h0093, 8'h00);

      // Reset in the middle of a refill
      addr_cpu = 16'h0155;
      rd_cpu   = 1'b1;
      @(posedge clock);
      #1;
      check("alloc_rd_mem", 32'(rd_mem), 32'd1);
      check("alloc_addr_mem", 32'(addr_mem), 32'h0155);
      rd_cpu  = 1'b0;
      reset_n = 1'b0;
      @(posedge clock);
      #1;
      check("abort_rd_mem", 32'(rd_mem), 32'd0);
      check("abort_stall", 32'(stall_cpu), 32'd0);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      exp_q.delete();
      wb_q.delete();
      fill_q.delete();
      model_clear_cache();
      issue(1, 0, 16'h0093, 8'h00);
      issue(1, 0, 16'h0013, 8'h00);
      issue(1, 0, 16'h0155, 8'h00);

      // Read and write together on a hit: the write wins
      issue(1, 1, 16'h0093, 8'h5A);
      issue(1, 0, 16'h0093, 8'h00);

      // Random traffic over a few sets with several tags each
      for (int i = 0; i < 300; i++) begin
         logic [15:0] a;
         bit          w;
         bit          r;
         a = {12'($urandom_range(0, 5)), 4'($urandom_range(0, 3))};
         w = ($urandom_range(0, 2) == 0);
         r = !w || ($urandom_range(0, 3) == 0);
         issue(r, w, a, 8'($urandom_range(0, 255)));
      end

      repeat (3) @(posedge clock);
      #1;
      check("exp_q_drained", 32'(exp_q.size()), 32'd0);
      check("wb_q_drained", 32'(wb_q.size()), 32'd0);
      check("fill_q_drained", 32'(fill_q.size()), 32'd0);
`ifdef CACHE_STATS_EN
      check("hit_count", 32'(hit_count), 32'(ref_hits));
      check("miss_count", 32'(miss_count), 32'(ref_misses));
`endif
      report();
   end

endmodule
